// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz VGA timing definitions.
// Holds the per-axis visible/front-porch/sync/back-porch lengths, the derived
// totals, the default counter width and the sync polarity, plus a phase
// decode helper. The downstream bit generator imports this package for its
// visible-region limits, so any change here moves both sides together.
package vga_pkg;

  localparam int VGA_COUNTER_BITS = 10;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Level driven on hsync/vsync during the sync pulse (640x480 uses negative sync).
  localparam logic VGA_SYNC_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    PH_VISIBLE = 2'd0,
    PH_FRONT   = 2'd1,
    PH_SYNC    = 2'd2,
    PH_BACK    = 2'd3
  } axis_phase_e;

  // Classify a position on one axis; 0 is the first visible pixel/line.
  function automatic axis_phase_e axis_phase(input int pos, input int vis,
                                             input int front, input int sync);
    axis_phase_e ph;
    if (pos < vis) begin
      ph = PH_VISIBLE;
    end else if (pos < vis + front) begin
      ph = PH_FRONT;
    end else if (pos < vis + front + sync) begin
      ph = PH_SYNC;
    end else begin
      ph = PH_BACK;
    end
    return ph;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus phase decode.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   step       : advance the position by one this cycle
//   count      : current position, 0..TOTAL-1 (0 = first visible)
//   wrap       : count is at TOTAL-1 (the next step returns it to 0)
//   sync_n     : 0 when the position after this cycle's step lies in the
//                sync window (polarity-neutral; the top applies SYNC_ACTIVE)
//   visible    : 1 when the position after this cycle's step is visible
// sync_n/visible look at the post-step value so the parent can register them
// on the same edge as the counter and keep them aligned with count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int COUNTER_BITS = VGA_COUNTER_BITS,
  parameter int VIS          = VGA_H_VISIBLE,
  parameter int FRONT        = VGA_H_FRONT,
  parameter int SYNC         = VGA_H_SYNC,
  parameter int BACK         = VGA_H_BACK
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step,
  output logic [COUNTER_BITS-1:0] count,
  output logic                    wrap,
  output logic                    sync_n,
  output logic                    visible
);

  localparam int TOTAL = VIS + FRONT + SYNC + BACK;

  logic [COUNTER_BITS-1:0] count_r;
  logic [COUNTER_BITS-1:0] next_count_s;
  logic                    at_last_s;
  axis_phase_e             next_phase_s;

  assign at_last_s = (count_r == COUNTER_BITS'(TOTAL - 1));

  // Next position: wrap at TOTAL-1, otherwise increment; hold without a step.
  always_comb begin
    next_count_s = count_r;
    if (step) begin
      if (at_last_s) begin
        next_count_s = '0;
      end else begin
        next_count_s = count_r + COUNTER_BITS'(1);
      end
    end else begin
      next_count_s = count_r;
    end
  end

  // Position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else begin
      count_r <= next_count_s;
    end
  end

  assign next_phase_s = axis_phase(int'(next_count_s), VIS, FRONT, SYNC);

  assign count   = count_r;
  assign wrap    = at_last_s;
  assign sync_n  = (next_phase_s != PH_SYNC);
  assign visible = (next_phase_s == PH_VISIBLE);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator (640x480@60 Hz from a 50 MHz clock by default).
// Ports:
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   en          : run enable; 0 freezes divider, counters and outputs
//   pix_en      : one-clk pulse per pixel advance (combinational from divider)
//   h_count     : horizontal position, 0..H_TOTAL-1, 0 = first visible pixel
//   v_count     : vertical position, 0..V_TOTAL-1, 0 = first visible line
//   hsync/vsync : sync outputs, SYNC_ACTIVE inside the sync window
//   bright      : 1 only inside the visible region
//   frame_start : one-clk pulse on the first cycle at (0,0) after a frame wrap
// hsync/vsync/bright are registered on pix_en from the post-step counter
// values, so they line up with h_count/v_count. After reset they stay
// inactive until the first pix_en, which moves h_count to 1: pixel (0,0) of
// the first frame after reset is deliberately blanked.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int   COUNTER_BITS = VGA_COUNTER_BITS,
  parameter int   CLK_DIV      = 2,
  parameter int   H_VISIBLE    = VGA_H_VISIBLE,
  parameter int   H_FRONT      = VGA_H_FRONT,
  parameter int   H_SYNC       = VGA_H_SYNC,
  parameter int   H_BACK       = VGA_H_BACK,
  parameter int   V_VISIBLE    = VGA_V_VISIBLE,
  parameter int   V_FRONT      = VGA_V_FRONT,
  parameter int   V_SYNC       = VGA_V_SYNC,
  parameter int   V_BACK       = VGA_V_BACK,
  parameter logic SYNC_ACTIVE  = VGA_SYNC_ACTIVE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic                    pix_en,
  output logic [COUNTER_BITS-1:0] h_count,
  output logic [COUNTER_BITS-1:0] v_count,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    bright,
  output logic                    frame_start
);

  // CLK_DIV = 1 still gets a 1-bit divider that simply stays at 0.
  localparam int DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_BITS-1:0] div_cnt_r;
  logic                pix_en_s;
  logic                h_wrap_s;
  logic                v_wrap_s;
  logic                v_step_s;
  logic                h_sync_n_s;
  logic                v_sync_n_s;
  logic                h_visible_s;
  logic                v_visible_s;
  logic                hsync_r;
  logic                vsync_r;
  logic                bright_r;
  logic                frame_start_r;

  assign pix_en_s = en && (div_cnt_r == DIV_BITS'(CLK_DIV - 1));

  // Pixel-rate divider; holds its phase while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
    end else if (pix_en_s) begin
      div_cnt_r <= '0;
    end else if (en) begin
      div_cnt_r <= div_cnt_r + DIV_BITS'(1);
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  vga_axis_counter #(
    .COUNTER_BITS (COUNTER_BITS),
    .VIS          (H_VISIBLE),
    .FRONT        (H_FRONT),
    .SYNC         (H_SYNC),
    .BACK         (H_BACK)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (pix_en_s),
    .count   (h_count),
    .wrap    (h_wrap_s),
    .sync_n  (h_sync_n_s),
    .visible (h_visible_s)
  );

  // The line counter moves only on the pixel that wraps the horizontal axis.
  assign v_step_s = pix_en_s && h_wrap_s;

  vga_axis_counter #(
    .COUNTER_BITS (COUNTER_BITS),
    .VIS          (V_VISIBLE),
    .FRONT        (V_FRONT),
    .SYNC         (V_SYNC),
    .BACK         (V_BACK)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (v_step_s),
    .count   (v_count),
    .wrap    (v_wrap_s),
    .sync_n  (v_sync_n_s),
    .visible (v_visible_s)
  );

  // Sync and blanking registers, loaded with the decode of the post-step position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_r  <= ~SYNC_ACTIVE;
      vsync_r  <= ~SYNC_ACTIVE;
      bright_r <= 1'b0;
    end else if (pix_en_s) begin
      hsync_r  <= h_sync_n_s ? ~SYNC_ACTIVE : SYNC_ACTIVE;
      vsync_r  <= v_sync_n_s ? ~SYNC_ACTIVE : SYNC_ACTIVE;
      bright_r <= h_visible_s && v_visible_s;
    end else begin
      hsync_r  <= hsync_r;
      vsync_r  <= vsync_r;
      bright_r <= bright_r;
    end
  end

  // Frame strobe: set on the edge where both axes wrap, cleared on every other edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= pix_en_s && h_wrap_s && v_wrap_s;
    end
  end

  assign pix_en      = pix_en_s;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign bright      = bright_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: three instances share clk/rst_n/en. u_dut uses
// the real 640x480 timing; u_sa and u_sb use a tiny raster so whole frames
// fit in a short run. A reference model derives every expected output from
// the number of enabled clocks since reset (linear pixel index arithmetic).
module tb_vga_timing_ctrl;

  localparam int S_HV = 8;
  localparam int S_HF = 2;
  localparam int S_HS = 3;
  localparam int S_HB = 2;
  localparam int S_VV = 4;
  localparam int S_VF = 1;
  localparam int S_VS = 2;
  localparam int S_VB = 2;

  typedef struct {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
    int div; int sa;
  } tim_t;

  typedef struct {
    int pix_en; int h; int v; int hsync; int vsync; int bright; int frame_start;
  } obs_t;

  typedef struct {
    int npix; int exp_h; int exp_v; int exp_bright; int exp_hsync; int exp_vsync;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       pe0, hs0, vs0, br0, fs0;
  logic [9:0] hc0, vc0;
  logic       pe1, hs1, vs1, br1, fs1;
  logic [3:0] hc1, vc1;
  logic       pe2, hs2, vs2, br2, fs2;
  logic [3:0] hc2, vc2;

  vga_timing_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_en(pe0), .h_count(hc0), .v_count(vc0),
    .hsync(hs0), .vsync(vs0), .bright(br0), .frame_start(fs0)
  );

  vga_timing_ctrl #(
    .COUNTER_BITS(4), .CLK_DIV(3),
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_ACTIVE(1'b1)
  ) u_sa (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_en(pe1), .h_count(hc1), .v_count(vc1),
    .hsync(hs1), .vsync(vs1), .bright(br1), .frame_start(fs1)
  );

  vga_timing_ctrl #(
    .COUNTER_BITS(4), .CLK_DIV(1),
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_ACTIVE(1'b0)
  ) u_sb (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_en(pe2), .h_count(hc2), .v_count(vc2),
    .hsync(hs2), .vsync(vs2), .bright(br2), .frame_start(fs2)
  );

  always #5 clk = ~clk;

  int    tests_run    = 0;
  int    tests_failed = 0;
  int    tick         = 0;   // enabled clock edges since reset release
  int    fs_exp [3];
  tim_t  tim [3];
  string nm [3];
  vec_t  vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic obs_t sample(input int i);
    obs_t o;
    case (i)
      0: o = '{int'(pe0), int'(hc0), int'(vc0), int'(hs0), int'(vs0), int'(br0), int'(fs0)};
      1: o = '{int'(pe1), int'(hc1), int'(vc1), int'(hs1), int'(vs1), int'(br1), int'(fs1)};
      2: o = '{int'(pe2), int'(hc2), int'(vc2), int'(hs2), int'(vs2), int'(br2), int'(fs2)};
      default: o = '{0, 0, 0, 0, 0, 0, 0};
    endcase
    return o;
  endfunction

  // Expected outputs after tk enabled clocks: pixel n = tk/div, linear index in frame.
  function automatic obs_t model(input tim_t t, input int tk, input int fs, input int en_now);
    obs_t e;
    int ht, vt, n, idx, h, v;
    ht  = t.hv + t.hf + t.hs + t.hb;
    vt  = t.vv + t.vf + t.vs + t.vb;
    n   = tk / t.div;
    idx = n % (ht * vt);
    h   = idx % ht;
    v   = idx / ht;
    e.pix_en = (en_now != 0 && (tk % t.div) == t.div - 1) ? 1 : 0;
    e.h = h;
    e.v = v;
    if (n == 0) begin
      e.bright = 0;
      e.hsync  = 1 - t.sa;
      e.vsync  = 1 - t.sa;
    end else begin
      e.bright = (h < t.hv && v < t.vv) ? 1 : 0;
      e.hsync  = (h >= t.hv + t.hf && h < t.hv + t.hf + t.hs) ? t.sa : 1 - t.sa;
      e.vsync  = (v >= t.vv + t.vf && v < t.vv + t.vf + t.vs) ? t.sa : 1 - t.sa;
    end
    e.frame_start = fs;
    return e;
  endfunction

  function automatic int frame_edge(input tim_t t, input int tk);
    int n, frame;
    n     = tk / t.div;
    frame = (t.hv + t.hf + t.hs + t.hb) * (t.vv + t.vf + t.vs + t.vb);
    return ((tk % t.div) == 0 && n > 0 && (n % frame) == 0) ? 1 : 0;
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      obs_t e, o;
      e = model(tim[i], tick, fs_exp[i], int'(en));
      o = sample(i);
      chk({nm[i], ".pix_en"},      o.pix_en,      e.pix_en);
      chk({nm[i], ".h_count"},     o.h,           e.h);
      chk({nm[i], ".v_count"},     o.v,           e.v);
      chk({nm[i], ".hsync"},       o.hsync,       e.hsync);
      chk({nm[i], ".vsync"},       o.vsync,       e.vsync);
      chk({nm[i], ".bright"},      o.bright,      e.bright);
      chk({nm[i], ".frame_start"}, o.frame_start, e.frame_start);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 3; i++) begin
      obs_t o;
      o = sample(i);
      chk({tag, ".", nm[i], ".h_count"},     o.h,           0);
      chk({tag, ".", nm[i], ".v_count"},     o.v,           0);
      chk({tag, ".", nm[i], ".bright"},      o.bright,      0);
      chk({tag, ".", nm[i], ".hsync"},       o.hsync,       1 - tim[i].sa);
      chk({tag, ".", nm[i], ".vsync"},       o.vsync,       1 - tim[i].sa);
      chk({tag, ".", nm[i], ".frame_start"}, o.frame_start, 0);
    end
  endtask

  // One clock: apply en, check the settled state, advance the model at the edge.
  task automatic cycle(input bit en_v);
    en = en_v;
    #1;
    check_all();
    @(posedge clk);
    if (rst_n) begin
      if (en_v) tick++;
      for (int i = 0; i < 3; i++) fs_exp[i] = en_v ? frame_edge(tim[i], tick) : 0;
    end else begin
      for (int i = 0; i < 3; i++) fs_exp[i] = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   target;
    int   first_a, second_a, first_b, second_b, fs_dut_cnt;

    nm[0] = "u_dut"; nm[1] = "u_sa"; nm[2] = "u_sb";
    tim[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 0};
    tim[1] = '{S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 3, 1};
    tim[2] = '{S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1, 0};
    for (int i = 0; i < 3; i++) fs_exp[i] = 0;

    // Cumulative pixel steps from reset through the first line of u_dut.
    vecs[0] = '{1,   1,   0, 1, 1, 1};
    vecs[1] = '{638, 639, 0, 1, 1, 1};
    vecs[2] = '{1,   640, 0, 0, 1, 1};
    vecs[3] = '{15,  655, 0, 0, 1, 1};
    vecs[4] = '{1,   656, 0, 0, 0, 1};
    vecs[5] = '{95,  751, 0, 0, 0, 1};
    vecs[6] = '{1,   752, 0, 0, 1, 1};
    vecs[7] = '{47,  799, 0, 0, 1, 1};
    vecs[8] = '{1,   0,   1, 1, 1, 1};

    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all();
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // First line of the full-size raster, table driven.
    for (int k = 0; k < 9; k++) begin
      target = tick / 2 + vecs[k].npix;
      while (tick / 2 < target) cycle(1'b1);
      o = sample(0);
      chk($sformatf("vec%0d.h_count", k), o.h,      vecs[k].exp_h);
      chk($sformatf("vec%0d.v_count", k), o.v,      vecs[k].exp_v);
      chk($sformatf("vec%0d.bright", k),  o.bright, vecs[k].exp_bright);
      chk($sformatf("vec%0d.hsync", k),   o.hsync,  vecs[k].exp_hsync);
      chk($sformatf("vec%0d.vsync", k),   o.vsync,  vecs[k].exp_vsync);
    end

    // Freeze at h = 320 with the divider mid-phase, then resume.
    while (tick / 2 < 800 + 320) cycle(1'b1);
    cycle(1'b1);
    repeat (7) cycle(1'b0);
    o = sample(0);
    chk("freeze.h_count", o.h, 320);
    chk("freeze.pix_en", o.pix_en, 0);
    en = 1'b1;
    #1;
    o = sample(0);
    chk("resume.pix_en", o.pix_en, 1);
    cycle(1'b1);
    o = sample(0);
    chk("resume.h_count", o.h, 321);

    // Randomised enable pattern.
    repeat (2500) cycle($urandom_range(0, 3) != 0);

    // Frame period with en held high.
    first_a = -1; second_a = -1; first_b = -1; second_b = -1;
    for (int c = 0; c < 1200; c++) begin
      cycle(1'b1);
      o = sample(1);
      if (o.frame_start != 0) begin
        if (first_a < 0) first_a = c;
        else if (second_a < 0) second_a = c;
      end
      o = sample(2);
      if (o.frame_start != 0) begin
        if (first_b < 0) first_b = c;
        else if (second_b < 0) second_b = c;
      end
    end
    chk("u_sa.frame_period", (first_a < 0 || second_a < 0) ? -1 : second_a - first_a, 405);
    chk("u_sb.frame_period", (first_b < 0 || second_b < 0) ? -1 : second_b - first_b, 135);

    // Asynchronous reset between clock edges, mid-frame.
    repeat (37) cycle(1'b1);
    #2;
    rst_n = 1'b0;
    tick  = 0;
    for (int i = 0; i < 3; i++) fs_exp[i] = 0;
    #1;
    check_reset_vals("async_reset");
    check_all();
    @(negedge clk);
    repeat (3) cycle(1'b1);
    rst_n = 1'b1;
    first_a = -1; first_b = -1; fs_dut_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      cycle(1'b1);
      o = sample(0);
      if (o.frame_start != 0) fs_dut_cnt++;
      o = sample(1);
      if (o.frame_start != 0 && first_a < 0) first_a = c;
      o = sample(2);
      if (o.frame_start != 0 && first_b < 0) first_b = c;
    end
    chk("post_reset.u_dut.frame_start_count", fs_dut_cnt, 0);
    chk("post_reset.u_sa.first_frame_start", first_a, 404);
    chk("post_reset.u_sb.first_frame_start", first_b, 134);
    cycle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
